// File: rtl/sigrok_pkg.sv
// Shared definitions for the sigrok bring-up pattern generator family.
package sigrok_pkg;

  // Board oscillator frequency used to size the default divider.
  localparam int unsigned CLK_FREQ_HZ = 27_000_000;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_STOP,
    ST_GAP
  } state_e;

  // Width of a counter that must hold the values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push button conditioner: 2-flop synchroniser, debounce counter,
// and a single-cycle press event once the button has been stably low for
// DEBOUNCE cycles. A release must be seen before the next event.
module button_debounce
  import sigrok_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_evt_o
);

  // Counter saturates one past DEBOUNCE so the event fires once per press.
  localparam int CNT_W = cnt_w(DEBOUNCE + 2);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Next-state of the debounce counter and press event.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (which would infer a latch).
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = (cnt_q == CNT_HIT);
  end

  // Synchroniser, counter and event registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      // NOTE: the synchroniser resets to the released level so a reset never looks like a press.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_evt_o = press_q;

endmodule

// File: rtl/sigrok_pattern_gen.sv
// Button-triggered multi-lane serial pattern generator. Each frame is
// START, WORD_W bits MSB first on every lane (lane k carries frame_cnt+k),
// STOP and an idle GAP; sck/sda are registered.
module sigrok_pattern_gen
  import sigrok_pkg::*;
#(
  parameter int CLK_DIV  = 27,
  parameter int WORD_W   = 8,
  parameter int LANES    = 2,
  parameter int DEBOUNCE = 16,
  parameter int GAP_HALF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bbutton,
  input  logic              cont,
  output logic              sck,
  output logic [LANES-1:0]  sda,
  output logic              busy,
  output logic              frame_done,
  output logic [WORD_W-1:0] frame_cnt
);

  localparam int DIV_W  = cnt_w(CLK_DIV);
  localparam int HALF_N = (2 * WORD_W > GAP_HALF) ? 2 * WORD_W : GAP_HALF;
  localparam int HALF_W = cnt_w(HALF_N);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] SHIFT_LAST = HALF_W'(2 * WORD_W - 1);
  localparam logic [HALF_W-1:0] GAP_LAST   = HALF_W'(GAP_HALF - 1);
  localparam logic [HALF_W-1:0] STOP_LAST  = HALF_W'(1);

  state_e                         state_q, state_d;
  logic [DIV_W-1:0]               div_q, div_d;
  logic [HALF_W-1:0]              half_q, half_d;
  logic [LANES-1:0][WORD_W-1:0]   shift_q, shift_d;
  logic [LANES-1:0][WORD_W-1:0]   payload, shifted;
  logic [LANES-1:0]               lane_msb;
  logic                           sck_q, sck_d;
  logic [LANES-1:0]               sda_q, sda_d;
  logic [WORD_W-1:0]              frame_cnt_q, frame_cnt_d;
  logic                           press_evt;
  logic                           tick;

  button_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .btn_n_i     (bbutton),
    .press_evt_o (press_evt)
  );

  assign tick = (div_q == DIV_LAST);

  // Per-lane helpers: new payload, current MSB and the shifted word.
  always_comb begin
    payload  = '0;
    shifted  = '0;
    lane_msb = '0;
    for (int k = 0; k < LANES; k++) begin
      payload[k]  = frame_cnt_q + WORD_W'(k);
      shifted[k]  = {shift_q[k][WORD_W-2:0], 1'b0};
      lane_msb[k] = shift_q[k][WORD_W-1];
    end
  end

  // Frame sequencer: next state, half-period bookkeeping and output levels.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    sda_d       = sda_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q != ST_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sck_d = 1'b1;
        sda_d = '1;
        if (press_evt) begin
          state_d = ST_START;
          div_d   = '0;
          half_d  = '0;
          shift_d = payload;
          sda_d   = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d = ST_SHIFT;
          half_d  = '0;
          sck_d   = 1'b0;
          sda_d   = lane_msb;
          shift_d = shifted;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (half_q == SHIFT_LAST) begin
            state_d = ST_STOP;
            half_d  = '0;
            sck_d   = 1'b1;
            sda_d   = '0;
          end else begin
            half_d = half_q + 1'b1;
            if (!half_q[0]) begin
              // Low half ends: raise sck, data stays put.
              sck_d = 1'b1;
            end else begin
              // High half ends: falling edge launches the next bit.
              sck_d   = 1'b0;
              sda_d   = lane_msb;
              shift_d = shifted;
            end
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (half_q != STOP_LAST) begin
            half_d = half_q + 1'b1;
            sda_d  = '1;
          end else begin
            state_d     = ST_GAP;
            half_d      = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          if (half_q == GAP_LAST) begin
            half_d = '0;
            if (cont) begin
              state_d = ST_START;
              shift_d = payload;
              sda_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      half_q      <= '0;
      shift_q     <= '0;
      sck_q       <= 1'b1;
      sda_q       <= '1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      sck_q       <= sck_d;
      sda_q       <= sda_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sck        = sck_q;
  assign sda        = sda_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_STOP) && (half_q == STOP_LAST) && tick;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sigrok_pattern_gen.sv
// Self-checking bench for sigrok_pattern_gen: a timeline model of frames
// checked every cycle, a capture decoder, and literal checks per scenario.
module tb_sigrok_pattern_gen;

  localparam int CLK_DIV   = 4;
  localparam int WORD_W    = 8;
  localparam int LANES     = 2;
  localparam int DEBOUNCE  = 8;
  localparam int GAP_HALF  = 2;
  localparam int WMOD      = 1 << WORD_W;
  localparam int STOP_END  = (2 * WORD_W + 3) * CLK_DIV;
  localparam int FRAME_LEN = (2 * WORD_W + 3 + GAP_HALF) * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bbutton = 1'b1;
  logic              cont = 1'b0;
  logic              sck;
  logic [LANES-1:0]  sda;
  logic              busy;
  logic              frame_done;
  logic [WORD_W-1:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  sigrok_pattern_gen #(
    .CLK_DIV  (CLK_DIV),
    .WORD_W   (WORD_W),
    .LANES    (LANES),
    .DEBOUNCE (DEBOUNCE),
    .GAP_HALF (GAP_HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bbutton    (bbutton),
    .cont       (cont),
    .sck        (sck),
    .sda        (sda),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button: a press registers when the raw sample taken three edges ago
  // completed a run of exactly DEBOUNCE consecutive lows.
  // Frame: a timeline offset from the START edge; outputs follow from it.
  bit m_valid = 0, m_active = 0, m_press = 0, start_now;
  int r1 = 0, r2 = 0, r3 = 0;
  int m_off = 0, m_cnt = 0, m_base = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_valid = 1; m_active = 0; m_press = 0;
      r1 = 0; r2 = 0; r3 = 0; m_cnt = 0;
    end else if (m_valid) begin
      start_now = 0;
      if (m_active) begin
        m_off++;
        if (m_off == STOP_END) m_cnt = (m_cnt + 1) % WMOD;
        if (m_off == FRAME_LEN) begin
          if (cont) start_now = 1;
          else      m_active  = 0;
        end
      end else if (m_press) begin
        start_now = 1;
      end
      if (start_now) begin
        m_active = 1; m_off = 0; m_base = m_cnt;
      end
      m_press = (r3 == DEBOUNCE);
      r3 = r2; r2 = r1;
      r1 = bbutton ? 0 : r1 + 1;
    end
  end

  // ---------------- per-cycle compare + capture decoder ----------------
  logic              e_sck, e_busy, e_done;
  logic [LANES-1:0]  e_sda;
  int                h, j, b;
  logic              prev_sck = 1'b1;
  logic [WORD_W-1:0] dec_w [LANES];
  int                bitcnt = 0, last_rise = 0, last_gap = 0;
  int                done_seen = 0;
  logic [31:0]       dec_words [$];
  int                done_cyc [$];

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      e_sck = 1'b1; e_sda = '1; e_busy = 1'b0; e_done = 1'b0;
      if (m_active) begin
        h = m_off / CLK_DIV;
        e_busy = 1'b1;
        e_done = (m_off == STOP_END - 1);
        if (h == 0) begin
          e_sda = '0;
        end else if (h <= 2 * WORD_W) begin
          j = h - 1;
          e_sck = (j % 2 == 1);
          b = WORD_W - 1 - j / 2;
          for (int k = 0; k < LANES; k++)
            e_sda[k] = 1'(((m_base + k) % WMOD) >> b);
        end else if (h == 2 * WORD_W + 1) begin
          e_sda = '0;
        end
      end
      check("model_sck", sck, e_sck);
      check("model_sda", sda, e_sda);
      check("model_busy", busy, e_busy);
      check("model_frame_done", frame_done, e_done);
      check("model_frame_cnt", frame_cnt, m_cnt);

      if (frame_done === 1'b1) begin
        done_seen++;
        done_cyc.push_back(cyc);
      end
      if (busy !== 1'b1) bitcnt = 0;
      else if (sck === 1'b1 && prev_sck === 1'b0) begin
        if (bitcnt > 0) last_gap = cyc - last_rise;
        last_rise = cyc;
        for (int k = 0; k < LANES; k++) dec_w[k] = {dec_w[k][WORD_W-2:0], sda[k]};
        bitcnt++;
        if (bitcnt == WORD_W) begin
          dec_words.push_back({16'h0, dec_w[1], dec_w[0]});
          bitcnt = 0;
        end
      end
      prev_sck = sck;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int target);
    if (target > cyc) step(target - cyc);
  endtask

  task automatic press_btn(input int n);
    bbutton = 1'b0;
    step(n);
    bbutton = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      step(1);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_word(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = (dec_words.size() > 0) ? dec_words.pop_front() : 32'hxxxx_xxxx;
    check(name, got, exp);
  endtask

  int p, s_edge, d0;

  initial begin
    // 1. reset and idle stability
    step(3);
    rst = 1'b0;
    check("rst_sck", sck, 1'b1);
    check("rst_sda", sda, 2'b11);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 8'h00);
    step(100);
    check("idle_sda", sda, 2'b11);
    check("idle_busy", busy, 1'b0);

    // 2. single shot with exact START timing
    p = cyc;
    bbutton = 1'b0;
    step(11);
    check("t2_sda_before_start", sda, 2'b11);
    step(1);
    check("t2_sda_start", sda, 2'b00);
    check("t2_busy_start", busy, 1'b1);
    s_edge = p + 12;
    d0 = done_seen;
    step(18);
    bbutton = 1'b1;
    goto_cyc(s_edge + FRAME_LEN - 1);
    check("t2_busy_last", busy, 1'b1);
    step(1);
    check("t2_busy_end", busy, 1'b0);
    check("t2_frame_cnt", frame_cnt, 8'h01);
    check("t2_done_pulses", done_seen - d0, 1);
    check("t2_sck_period", last_gap, 2 * CLK_DIV);
    check_word("t2_word0", 32'h0100);
    step(5);
    press_btn(30);
    wait_idle("t2_second_idle", 200);
    check_word("t2_word1", 32'h0201);
    check("t2_frame_cnt2", frame_cnt, 8'h02);

    // 3. glitch rejection, debounce boundary, press while busy
    step(5);
    press_btn(5);
    step(40);
    check("t3_glitch5_busy", busy, 1'b0);
    press_btn(DEBOUNCE - 1);
    step(40);
    check("t3_short_busy", busy, 1'b0);
    check("t3_frame_cnt_hold", frame_cnt, 8'h02);
    press_btn(DEBOUNCE);
    step(5);
    check("t3_exact_busy", busy, 1'b1);
    wait_idle("t3_exact_idle", 200);
    check_word("t3_word_exact", 32'h0302);
    step(5);
    d0 = done_seen;
    press_btn(30);
    step(10);
    press_btn(30);
    wait_idle("t3_busy_idle", 200);
    step(40);
    check("t3_busy_press_frames", done_seen - d0, 1);
    check("t3_frame_cnt", frame_cnt, 8'h04);
    check_word("t3_word_busy", 32'h0403);

    // 4. continuous mode, cont dropped in the third frame
    do_reset(3);
    dec_words.delete();
    done_cyc.delete();
    cont = 1'b1;
    p = cyc;
    press_btn(30);
    s_edge = p + 12;
    goto_cyc(s_edge + 2 * FRAME_LEN + 10);
    cont = 1'b0;
    wait_idle("t4_idle", 2 * FRAME_LEN);
    step(20);
    check("t4_frame_cnt", frame_cnt, 8'h03);
    check("t4_frames", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("t4_spacing01", done_cyc[1] - done_cyc[0], FRAME_LEN);
      check("t4_spacing12", done_cyc[2] - done_cyc[1], FRAME_LEN);
    end
    check_word("t4_word0", 32'h0100);
    check_word("t4_word1", 32'h0201);
    check_word("t4_word2", 32'h0302);

    // 5. reset in the middle of SHIFT bit 4
    dec_words.delete();
    p = cyc;
    press_btn(30);
    s_edge = p + 12;
    goto_cyc(s_edge + 29);
    check("t5_busy_before", busy, 1'b1);
    d0 = done_seen;
    rst = 1'b1;
    step(1);
    check("t5_sck", sck, 1'b1);
    check("t5_sda", sda, 2'b11);
    check("t5_busy", busy, 1'b0);
    check("t5_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    step(100);
    check("t5_no_done", done_seen - d0, 0);
    check("t5_no_word", dec_words.size(), 0);
    press_btn(30);
    wait_idle("t5_idle", 200);
    check_word("t5_word", 32'h0100);

    // random phase: presses of random length, cont toggling, occasional reset
    for (int it = 0; it < 40; it++) begin
      cont = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      press_btn($urandom_range(1, 20));
      step($urandom_range(1, 150));
      if ($urandom_range(0, 1) == 1) cont = ~cont;
      step($urandom_range(1, 60));
    end
    cont = 1'b0;
    wait_idle("rand_idle", 3 * FRAME_LEN);

    // 6. counter wrap after 255 continuous frames
    do_reset(2);
    dec_words.delete();
    cont = 1'b1;
    p = cyc;
    press_btn(30);
    s_edge = p + 12;
    goto_cyc(s_edge + 255 * FRAME_LEN + 10);
    cont = 1'b0;
    wait_idle("t6_idle", 2 * FRAME_LEN);
    check("t6_frames", dec_words.size(), 256);
    if (dec_words.size() == 256) begin
      check("t6_word_fe", dec_words[254], 32'hFFFE);
      check("t6_word_ff", dec_words[255], 32'h00FF);
    end
    check("t6_frame_cnt_wrap", frame_cnt, 8'h00);

    step(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sigrok_pattern_gen.md
Name: sigrok_pattern_gen

Overview:
Parametrised, button-triggered serial pattern generator for logic-analyzer (sigrok) bring-up. On a debounced press of the active-low board button it emits framed words on LANES parallel data lines sharing one serial clock (sck), with I2C-like start/stop framing. The frame payload is an incrementing frame counter, so captures can be decoded and checked. Supports single-shot and continuous modes. Sits at top level between the board button/27 MHz clock and the analyzer-probed pins.

Parameters:
CLK_DIV, 27, clk cycles per sck half-period (>=1); 27 gives 500 kHz sck at 27 MHz
WORD_W, 8, bits per word per lane (>=2)
LANES, 2, number of data lanes (>=1)
DEBOUNCE, 16, cycles bbutton must be stably low before a press registers (>=1)
GAP_HALF, 2, idle half-periods between consecutive frames (>=1)

Ports:
clk  in  1  system clock (27 MHz board clock)
rst  in  1  reset; synchronous, active-high
bbutton  in  1  board button, active-low, asynchronous
cont  in  1  1 = continuous mode, 0 = single-shot
sck  out  1  serial clock, idles high
sda  out  LANES  serial data, one bit per lane, idles all-ones
busy  out  1  high from START through GAP
frame_done  out  1  one-cycle pulse on the last cycle of STOP
frame_cnt  out  WORD_W  current frame counter value

Behaviour:
- Reset (rst=1 at a clk edge): next cycle sck=1, sda=all 1, busy=0, frame_done=0, frame_cnt=0, FSM=IDLE, divider=0, debounce state cleared. Applies mid-frame: the frame is abandoned with no STOP.
- Button path: 2-flop synchroniser on bbutton, then a debounce counter. The counter counts while the synced input is 0 and clears when it is 1. press_evt pulses one cycle when the counter reaches DEBOUNCE, once per press. Release must be seen (synced=1) before another press_evt.
- Latency: bbutton sampled low at edge t. If held, press_evt is high in cycle t+DEBOUNCE+2, and sda drops (START) at edge t+DEBOUNCE+3.
- Divider: counts 0..CLK_DIV-1 only while busy. tick = (div==CLK_DIV-1). One tick = one sck half-period. The divider resets to 0 on entry to START.
- FSM, with each state lasting whole half-periods:
  - IDLE: sck=1, sda=all 1. On press_evt, go to START and latch the shift registers: lane k gets (frame_cnt + k) mod 2^WORD_W.
  - START (1 half): sck=1, sda=all 0.
  - SHIFT (2*WORD_W halves), MSB first: on each low half, sck=0 and sda is updated at the sck falling edge; on each high half, sck=1 and sda is stable. Bit index counts down from WORD_W-1.
  - STOP (2 halves): first half sck=1, sda=0; second half sda=all 1. frame_done pulses on its last cycle. frame_cnt increments (wraps at 2^WORD_W) on that same edge.
  - GAP (GAP_HALF halves): idle levels. At the end of GAP, cont is sampled: if 1, go to START with the new payload; if 0, go to IDLE.
- press_evt while busy is ignored. Dropping cont mid-frame completes the current frame, then goes IDLE.
- sck/sda are registered outputs with no combinational path from inputs.
- Frame length = (2*WORD_W + 3 + GAP_HALF) * CLK_DIV cycles.

Decomposition:
- Shared package sigrok_pkg:
  - FSM state encoding (IDLE, START, SHIFT, STOP, GAP)
  - Width helper for the divider and bit-index counters ($clog2)
  - Default CLK_FREQ_HZ = 27_000_000
- One sub-module, button_debounce (synchroniser + debounce counter + press_evt), parametrised by DEBOUNCE. It is reused by later button-driven blocks.

Test Plan (CLK_DIV=4, WORD_W=8, LANES=2, DEBOUNCE=8, GAP_HALF=2 unless noted):
1. Reset: rst=1 for 3 cycles, release -> sck=1, sda=2'b11, busy=0, frame_cnt=0; all outputs stable for 100 cycles with the button idle.
2. Single shot: cont=0, bbutton low for 30 cycles from edge t.
   - sda=00 at edge t+11.
   - Lane0 decodes 0x00 and lane1 decodes 0x01 (MSB first, sampled on sck rising edges); sck period = 8 clk.
   - One frame_done pulse, frame_cnt=1, busy low after 21*4=84 cycles.
   - A second press gives 0x01/0x02.
3. Glitch rejection: bbutton low for 5 cycles, then high -> no press_evt, busy stays 0. A press held while busy -> no second frame.
4. Continuous: cont=1, one press -> back-to-back frames 0x00/0x01, 0x01/0x02, 0x02/0x03, each 84 cycles apart. Clear cont during the third frame -> that frame completes and the FSM returns to IDLE; frame_cnt=3.
5. Reset mid-frame: rst=1 during SHIFT bit 4 -> next cycle sck=1, sda=11, busy=0, no frame_done. The next press sends 0x00/0x01.
6. Wrap: with frame_cnt preloaded to 0xFF via 255 continuous frames, the next frame sends lane0 0xFF and lane1 0x00. frame_cnt then wraps to 0x00.
